pe_inst_sequencer: RTL and testbench

//  Per-PE instruction sequencer; drives the opcode/operand side of the CGRA ALU.
//  - Holds the PE's instruction memory, loaded through a config port while idle.
//  - On Start, steps a PC and issues one instruction per cycle: Opcode to the ALU,

---
 rtl/pe_inst_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_pe_inst_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_inst_sequencer.sv
// Per-PE instruction sequencer: instruction memory, PC stepping, issue and delayed writeback strobe.
// Optional feature macro PE_SEQ_LOOP_EN adds Loop_Num (program repeated Loop_Num+1 times).
module pe_inst_sequencer #(
   parameter int DMAW   = 8,
   parameter int IMAW   = 6,
   parameter int WB_LAT = 4
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Cfg_We,
   input  logic [IMAW-1:0]   Cfg_Addr,
   input  logic [4+4*DMAW:0] Cfg_Data,
   input  logic [IMAW:0]     Inst_Count,
   input  logic              Start,
`ifdef PE_SEQ_LOOP_EN
   input  logic [7:0]        Loop_Num,
`endif
   output logic              Busy,
   output logic              Done,
   output logic              Issue_Valid,
   output logic [3:0]        Opcode,
   output logic [DMAW-1:0]   Src0_Addr,
   output logic [DMAW-1:0]   Src1_Addr,
   output logic [DMAW-1:0]   Src2_Addr,
   output logic              Wb_En,
   output logic [DMAW-1:0]   Wb_Addr
);

   localparam int IWIDTH = 5 + 4*DMAW;
   localparam int DEPTH  = 2**IMAW;
   localparam int DCW    = (WB_LAT > 1) ? $clog2(WB_LAT) : 1;

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t            state_r, state_s;
   logic [IWIDTH-1:0] imem_r [DEPTH];
   logic [IWIDTH-1:0] inst_s;
   logic [IMAW-1:0]   pc_r;
   logic [IMAW:0]     rem_r, cnt_s, rem_reload_s;
   logic [DCW-1:0]    drain_r;
   logic              start_ok_s, load_s, wrap_s;
   logic              busy_r, done_r, busy_s, done_s;
   logic              issue_valid_r, we_r;
   logic [3:0]        opcode_r;
   logic [DMAW-1:0]   src0_r, src1_r, src2_r, dst_r;
   logic              wb_en_r   [WB_LAT];
   logic [DMAW-1:0]   wb_addr_r [WB_LAT];

   assign start_ok_s = Start && (state_r == S_IDLE);
   assign cnt_s      = (Inst_Count > (IMAW+1)'(DEPTH)) ? (IMAW+1)'(DEPTH) : Inst_Count;
   // rem_r counts instructions still to be fetched in the current pass
   assign load_s     = (state_r == S_FETCH) || ((state_r == S_RUN) && (rem_r != (IMAW+1)'(0)));
   assign inst_s     = imem_r[pc_r];

`ifdef PE_SEQ_LOOP_EN
   logic [7:0]    loops_r;
   logic [IMAW:0] cnt_r;

   assign wrap_s       = (rem_r == (IMAW+1)'(1)) && (loops_r != 8'd0);
   assign rem_reload_s = cnt_r;

   // Pass counter and program length for the wrap back to PC 0.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         loops_r <= 8'd0;
         cnt_r   <= (IMAW+1)'(0);
      end else if (start_ok_s) begin
         loops_r <= Loop_Num;
         cnt_r   <= cnt_s;
      end else if (load_s && wrap_s) begin
         loops_r <= loops_r - 8'd1;
      end
   end
`else
   assign wrap_s       = 1'b0;
   assign rem_reload_s = (IMAW+1)'(0);
`endif

   // Instruction memory: written only while idle, contents survive Reset.
   always_ff @(posedge Clk) begin
      if (!Reset && Cfg_We && (state_r == S_IDLE)) begin
         imem_r[Cfg_Addr] <= Cfg_Data;
      end
   end

   // State register plus registered Busy/Done.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_r <= S_IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE:  begin
            if (start_ok_s) state_s = (cnt_s == (IMAW+1)'(0)) ? S_DONE : S_FETCH;
            else            state_s = S_IDLE;
         end
         S_FETCH: state_s = S_RUN;
         S_RUN:   begin
            if (rem_r == (IMAW+1)'(0)) state_s = S_DRAIN;
            else                       state_s = S_RUN;
         end
         S_DRAIN: begin
            if (drain_r == DCW'(0)) state_s = S_DONE;
            else                    state_s = S_DRAIN;
         end
         S_DONE:  state_s = S_IDLE;
         default: state_s = S_IDLE;
      endcase
   end

   // Output decode of the next state, registered alongside it.
   always_comb begin
      busy_s = (state_s != S_IDLE);
      done_s = (state_s == S_DONE);
   end

   // PC stepping, issue registers and drain timer.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         pc_r          <= IMAW'(0);
         rem_r         <= (IMAW+1)'(0);
         drain_r       <= DCW'(0);
         issue_valid_r <= 1'b0;
         we_r          <= 1'b0;
         opcode_r      <= 4'b0000;
         src0_r        <= DMAW'(0);
         src1_r        <= DMAW'(0);
         src2_r        <= DMAW'(0);
         dst_r         <= DMAW'(0);
      end else begin
         if (start_ok_s) begin
            pc_r  <= IMAW'(0);
            rem_r <= cnt_s;
         end else if (load_s && wrap_s) begin
            pc_r  <= IMAW'(0);
            rem_r <= rem_reload_s;
         end else if (load_s) begin
            pc_r  <= pc_r + IMAW'(1);
            rem_r <= rem_r - (IMAW+1)'(1);
         end
         if (load_s) begin
            issue_valid_r <= 1'b1;
            we_r          <= inst_s[IWIDTH-1];
            opcode_r      <= inst_s[IWIDTH-2 -: 4];
            src0_r        <= inst_s[4*DMAW-1 -: DMAW];
            src1_r        <= inst_s[3*DMAW-1 -: DMAW];
            src2_r        <= inst_s[2*DMAW-1 -: DMAW];
            dst_r         <= inst_s[DMAW-1:0];
         end else begin
            issue_valid_r <= 1'b0;
            opcode_r      <= 4'b0000;
         end
         if ((state_r == S_RUN) && (rem_r == (IMAW+1)'(0))) begin
            drain_r <= DCW'(WB_LAT-1);
         end else if ((state_r == S_DRAIN) && (drain_r != DCW'(0))) begin
            drain_r <= drain_r - DCW'(1);
         end
      end
   end

   // Writeback delay line: stage 0 is filled one cycle after issue.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < WB_LAT; i++) begin
            wb_en_r[i]   <= 1'b0;
            wb_addr_r[i] <= DMAW'(0);
         end
      end else begin
         wb_en_r[0]   <= issue_valid_r && we_r && (opcode_r != 4'b0000);
         wb_addr_r[0] <= dst_r;
         for (int i = 1; i < WB_LAT; i++) begin
            wb_en_r[i]   <= wb_en_r[i-1];
            wb_addr_r[i] <= wb_addr_r[i-1];
         end
      end
   end

   assign Busy        = busy_r;
   assign Done        = done_r;
   assign Issue_Valid = issue_valid_r;
   assign Opcode      = opcode_r;
   assign Src0_Addr   = src0_r;
   assign Src1_Addr   = src1_r;
   assign Src2_Addr   = src2_r;
   assign Wb_En       = wb_en_r[WB_LAT-1];
   assign Wb_Addr     = wb_addr_r[WB_LAT-1];

endmodule

// File: tb/tb_pe_inst_sequencer.sv
// Self-checking bench for pe_inst_sequencer: timeline reference model, vector table, random runs.
// Exercises Loop_Num only when PE_SEQ_LOOP_EN is defined.
module tb_pe_inst_sequencer;

   localparam int DMAW   = 8;
   localparam int IMAW   = 6;
   localparam int WB_LAT = 4;
   localparam int IW     = 5 + 4*DMAW;
   localparam int DEPTH  = 2**IMAW;

   logic            Clk = 1'b0;
   logic            Reset, Cfg_We, Start;
   logic [IMAW-1:0] Cfg_Addr;
   logic [IW-1:0]   Cfg_Data;
   logic [IMAW:0]   Inst_Count;
`ifdef PE_SEQ_LOOP_EN
   logic [7:0]      Loop_Num;
`endif
   logic            Busy, Done, Issue_Valid, Wb_En;
   logic [3:0]      Opcode;
   logic [DMAW-1:0] Src0_Addr, Src1_Addr, Src2_Addr, Wb_Addr;

   pe_inst_sequencer #(.DMAW(DMAW), .IMAW(IMAW), .WB_LAT(WB_LAT)) dut (
      .Clk(Clk), .Reset(Reset), .Cfg_We(Cfg_We), .Cfg_Addr(Cfg_Addr), .Cfg_Data(Cfg_Data),
      .Inst_Count(Inst_Count), .Start(Start),
`ifdef PE_SEQ_LOOP_EN
      .Loop_Num(Loop_Num),
`endif
      .Busy(Busy), .Done(Done), .Issue_Valid(Issue_Valid), .Opcode(Opcode),
      .Src0_Addr(Src0_Addr), .Src1_Addr(Src1_Addr), .Src2_Addr(Src2_Addr),
      .Wb_En(Wb_En), .Wb_Addr(Wb_Addr)
   );

   always #5 Clk = ~Clk;

   logic [IW-1:0]   prog_m [DEPTH];
   logic [DMAW-1:0] hold0, hold1, hold2;
   int errors = 0;
   int checks = 0;

   typedef struct {
      int n;
      int loops;
      bit disturb;
      bit wr_start;
      int exp_issues;
      int exp_done;
   } vec_t;
   vec_t tbl [$];

   function automatic logic [IW-1:0] mk(input logic we, input logic [3:0] op,
                                        input logic [7:0] s0, input logic [7:0] s1,
                                        input logic [7:0] s2, input logic [7:0] dst);
      return {we, op, s0, s1, s2, dst};
   endfunction

   function automatic logic [IW-1:0] rand_inst();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[IW-1:0];
   endfunction

   // {Busy, Done, Issue_Valid, Opcode, Src0, Src1, Src2, Wb_En, Wb_Addr}
   function automatic logic [39:0] got_vec(input bit raw);
      logic [7:0] wa;
      wa = (raw || Wb_En) ? Wb_Addr : 8'h00;
      return {Busy, Done, Issue_Valid, Opcode, Src0_Addr, Src1_Addr, Src2_Addr, Wb_En, wa};
   endfunction

   task automatic check(input string name, input logic [39:0] got, input logic [39:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic load(input int a, input logic [IW-1:0] d);
      Cfg_We   = 1'b1;
      Cfg_Addr = a[IMAW-1:0];
      Cfg_Data = d;
      @(negedge Clk);
      Cfg_We   = 1'b0;
      prog_m[a] = d;
   endtask

   // Expected outputs j cycles after the Start edge, from the issue/writeback timeline.
   task automatic model_exp(input int j, input int cnt, input int total, input int done_off,
                            output logic [39:0] e);
      logic          iv, wbe;
      logic [3:0]    op;
      logic [7:0]    wba;
      logic [IW-1:0] w;
      int            m;
      iv = (cnt > 0) && (j >= 2) && (j < 2 + total);
      op = 4'h0;
      if (iv) begin
         w     = prog_m[(j-2) % cnt];
         op    = w[IW-2 -: 4];
         hold0 = w[31:24];
         hold1 = w[23:16];
         hold2 = w[15:8];
      end
      wbe = 1'b0;
      wba = 8'h00;
      m   = j - 2 - WB_LAT;
      if ((cnt > 0) && (m >= 0) && (m < total)) begin
         w = prog_m[m % cnt];
         if (w[IW-1] && (w[IW-2 -: 4] != 4'h0)) begin
            wbe = 1'b1;
            wba = w[7:0];
         end
      end
      e = {(j >= 1 && j <= done_off), (j == done_off), iv, op, hold0, hold1, hold2, wbe, wba};
   endtask

   task automatic run_prog(input string name, input int n, input int loops, input bit disturb,
                           input bit wr_start, output int issues, output int done_seen);
      int            cnt, total, done_off;
      logic [39:0]   e;
      logic [IW-1:0] d;
      cnt      = (n > DEPTH) ? DEPTH : n;
      total    = cnt * (loops + 1);
      done_off = (cnt == 0) ? 1 : total + WB_LAT + 2;
      Start      = 1'b1;
      Inst_Count = n[IMAW:0];
`ifdef PE_SEQ_LOOP_EN
      Loop_Num   = loops[7:0];
`endif
      if (wr_start) begin
         d         = rand_inst();
         Cfg_We    = 1'b1;
         Cfg_Addr  = '0;
         Cfg_Data  = d;
         prog_m[0] = d;
      end
      issues    = 0;
      done_seen = -1;
      for (int j = 1; j <= done_off + 3; j++) begin
         @(negedge Clk);
         model_exp(j, cnt, total, done_off, e);
         check(name, got_vec(1'b0), e);
         if (Issue_Valid) issues++;
         if (Done && done_seen < 0) done_seen = j;
         Start  = 1'b0;
         Cfg_We = 1'b0;
         if (disturb && j == 2) begin
            Start      = 1'b1;
            Inst_Count = 7'd5;
            Cfg_We     = 1'b1;
            Cfg_Addr   = '0;
            Cfg_Data   = {IW{1'b1}};
         end
      end
   endtask

   initial begin
      int            iss, dn, n, lp;
      logic [39:0]   e;
      Reset = 1'b1; Cfg_We = 1'b0; Cfg_Addr = '0; Cfg_Data = '0; Inst_Count = '0; Start = 1'b0;
`ifdef PE_SEQ_LOOP_EN
      Loop_Num = 8'd0;
`endif
      hold0 = 8'h00; hold1 = 8'h00; hold2 = 8'h00;
      @(negedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge Clk);
         check("idle_after_reset", got_vec(1'b1), 40'h0);
      end

      for (int a = 0; a < DEPTH; a++) load(a, rand_inst());
      load(0, mk(1'b1, 4'd1, 8'd1, 8'd2, 8'd3, 8'd10));
      load(1, mk(1'b1, 4'd7, 8'd4, 8'd5, 8'd0, 8'd11));
      load(2, mk(1'b1, 4'd3, 8'd6, 8'd7, 8'd8, 8'd12));
      load(3, mk(1'b1, 4'd0, 8'd9, 8'd9, 8'd9, 8'd13));

      tbl.push_back('{0,   0, 1'b0, 1'b0, 0,  1});
      tbl.push_back('{3,   0, 1'b0, 1'b0, 3,  9});
      tbl.push_back('{4,   0, 1'b0, 1'b0, 4,  10});
      tbl.push_back('{3,   0, 1'b1, 1'b0, 3,  9});
      tbl.push_back('{1,   0, 1'b0, 1'b1, 1,  7});
      tbl.push_back('{64,  0, 1'b0, 1'b0, 64, 70});
      tbl.push_back('{100, 0, 1'b0, 1'b0, 64, 70});
      tbl.push_back('{127, 0, 1'b0, 1'b0, 64, 70});
`ifdef PE_SEQ_LOOP_EN
      tbl.push_back('{2,   2, 1'b0, 1'b0, 6,  12});
      tbl.push_back('{3,   1, 1'b1, 1'b0, 6,  12});
`endif
      foreach (tbl[t]) begin
         run_prog($sformatf("tbl%0d_cycle", t), tbl[t].n, tbl[t].loops, tbl[t].disturb,
                  tbl[t].wr_start, iss, dn);
         check($sformatf("tbl%0d_issues", t), 40'(iss), 40'(tbl[t].exp_issues));
         check($sformatf("tbl%0d_done_at", t), 40'(dn), 40'(tbl[t].exp_done));
      end

      // Reset on the second issue cycle aborts the run without Done.
      load(0, mk(1'b1, 4'd1, 8'd1, 8'd2, 8'd3, 8'd10));
      Start = 1'b1;
      Inst_Count = 7'd3;
`ifdef PE_SEQ_LOOP_EN
      Loop_Num = 8'd0;
`endif
      for (int j = 1; j <= 14; j++) begin
         @(negedge Clk);
         if (j <= 3) begin
            model_exp(j, 3, 3, 9, e);
            check("pre_reset", got_vec(1'b0), e);
         end else begin
            check("post_reset", got_vec(1'b1), 40'h0);
         end
         Start = 1'b0;
         Reset = (j == 3);
      end
      hold0 = 8'h00; hold1 = 8'h00; hold2 = 8'h00;
      run_prog("restart", 3, 0, 1'b0, 1'b0, iss, dn);
      check("restart_issues", 40'(iss), 40'd3);

      for (int r = 0; r < 20; r++) begin
         for (int k = 0; k < 4; k++) load($urandom_range(0, DEPTH-1), rand_inst());
         n  = $urandom_range(0, 70);
         lp = 0;
`ifdef PE_SEQ_LOOP_EN
         lp = $urandom_range(0, 3);
`endif
         run_prog($sformatf("rand%0d", r), n, lp, r[0], r[1] & r[2], iss, dn);
         @(negedge Clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
